t_ff_bank_arbiter: RTL and testbench

T_FF_BANK_ARBITER -- requirements
Module: t_ff_bank_arbiter

---
 rtl/t_ff_bank_arbiter.sv | 111 +++++++++++
 tb/tb_t_ff_bank_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/t_ff_bank_arbiter.sv
// t_ff_bank_arbiter
//   A shared bank of WIDTH T flip-flops. NREQ requesters take turns toggling it,
//   and a round-robin arbiter picks who goes next. Every grant is a fixed
//   3-cycle transaction: IDLE (grant) -> TOGGLE (t_out = mask) -> ACK (ack pulse).
//
// Ports
//   clk       : clock; all state changes happen on its rising edge
//   rst       : asynchronous reset, active low
//   req       : per-requester toggle request (level, held until ack)
//   req_mask  : packed toggle masks; slice i is bits i*WIDTH +: WIDTH
//   ack       : one-hot, one-cycle completion pulse to the served requester
//   grant_id  : index of the requester being served (keeps its last value in IDLE)
//   busy      : high whenever the FSM is not in IDLE
//   t_out     : toggle-enable vector applied to the bank this cycle
//   q         : current state of the T flip-flop bank
module t_ff_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_mask,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [WIDTH-1:0]         t_out,
  output logic [WIDTH-1:0]         q
);

  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StToggle, StAck} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_q, rr_d;

  logic             found;
  logic [GW-1:0]    win;
  int unsigned      idx;

  // Round-robin search: first requester at or above rr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(rr_q) + off) % NREQ;
      if (!found && req[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mask_d  = mask_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          // Snapshot the mask so later changes on req_mask cannot affect this transaction.
          grant_d = win;
          mask_d  = req_mask[32'(win)*WIDTH +: WIDTH];
          state_d = StToggle;
        end
      end
      StToggle: begin
        q_d     = q_q ^ mask_q;
        state_d = StAck;
      end
      StAck: begin
        rr_d    = GW'((32'(grant_q) + 1) % NREQ);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      mask_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Outputs are decoded from registered state only, so reset clears them at once.
  always_comb begin
    t_out    = (state_q == StToggle) ? mask_q : '0;
    ack      = (state_q == StAck) ? (NREQ'(1) << grant_q) : '0;
    busy     = (state_q != StIdle);
    grant_id = grant_q;
    q        = q_q;
  end

endmodule

// File: tb/tb_t_ff_bank_arbiter.sv
// Directed + randomized bench for t_ff_bank_arbiter. The reference model works
// at transaction level: it tracks the bank value, the round-robin pointer and
// the last grant. It picks each winner straight from the round-robin rule.
module tb_t_ff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ*WIDTH-1:0]   req_mask = '0;
  logic [NREQ-1:0]         ack;
  logic [1:0]              grant_id;
  logic                    busy;
  logic [WIDTH-1:0]        t_out;
  logic [WIDTH-1:0]        q;

  t_ff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_mask (req_mask),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .t_out    (t_out),
    .q        (q)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q     = '0;
  int               m_rr    = 0;
  int               m_grant = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int winner(input logic [NREQ-1:0] r, input int rr);
    for (int off = 0; off < NREQ; off++) begin
      if (r[(rr + off) % NREQ]) return (rr + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_ack"}, 32'(ack), 32'(0));
    check({tag, "_t_out"}, 32'(t_out), 32'(0));
    check({tag, "_q"}, 32'(q), 32'(m_q));
  endtask

  // One full transaction starting from IDLE. r2/m2 are driven right after the
  // grant edge and must not disturb the transaction in progress.
  task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] m,
                        input logic [NREQ-1:0] r2, input logic [NREQ*WIDTH-1:0] m2);
    int               w;
    logic [WIDTH-1:0] mk;
    req      = r;
    req_mask = m;
    w        = winner(r, m_rr);
    mk       = m[w*WIDTH +: WIDTH];
    tick();
    req      = r2;
    req_mask = m2;
    check("tgl_t_out", 32'(t_out), 32'(mk));
    check("tgl_busy", 32'(busy), 32'(1));
    check("tgl_ack", 32'(ack), 32'(0));
    check("tgl_grant", 32'(grant_id), 32'(w));
    check("tgl_q", 32'(q), 32'(m_q));
    tick();
    m_q = m_q ^ mk;
    check("ack_q", 32'(q), 32'(m_q));
    check("ack_pulse", 32'(ack), 32'(1) << w);
    check("ack_t_out", 32'(t_out), 32'(0));
    check("ack_busy", 32'(busy), 32'(1));
    check("ack_grant", 32'(grant_id), 32'(w));
    tick();
    m_rr    = (w + 1) % NREQ;
    m_grant = w;
    check_quiet("idle");
    check("idle_grant", 32'(grant_id), 32'(m_grant));
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] mm;
    logic [WIDTH-1:0]      xacc;
    logic [NREQ-1:0]       rr_req;

    // Reset and idle
    #1;
    check_quiet("rst_async");
    check("rst_grant", 32'(grant_id), 32'(0));
    tick();
    tick();
    check_quiet("rst_hold");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("idle_run");
    end

    // Single request, then repeat to restore q
    mm = '0;
    mm[7:0] = 8'hA5;
    do_txn(4'b0001, mm, 4'b0000, mm);
    check("single_q1", 32'(q), 32'h0000_00A5);
    do_txn(4'b0001, mm, 4'b0000, mm);
    check("single_q2", 32'(q), 32'h0000_0000);

    // Contention with all requests held: order 0,1,2,3,0 after a fresh reset
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_q = '0; m_rr = 0; m_grant = 0;
    mm = {8'h80, 8'h3C, 8'h11, 8'h06};
    xacc = '0;
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, mm, 4'b1111, mm);
      check("cont_order", 32'(grant_id), 32'(i % NREQ));
      xacc = xacc ^ mm[(i % NREQ)*WIDTH +: WIDTH];
    end
    check("cont_xor", 32'(q), 32'(xacc));

    // Round-robin wrap: serve 2 so pointer sits at 3, then 1001 -> 3 then 0
    do_txn(4'b0100, mm, 4'b0000, mm);
    check("wrap_grant2", 32'(grant_id), 32'(2));
    rr_req = 4'b1001;
    do_txn(rr_req, mm, rr_req, mm);
    check("wrap_grant3", 32'(grant_id), 32'(3));
    do_txn(rr_req, mm, 4'b0000, mm);
    check("wrap_grant0", 32'(grant_id), 32'(0));

    // Mask change after grant: 0F captured, F0 driven during TOGGLE
    xacc = q;
    mm = '0;
    mm[7:0] = 8'h0F;
    do_txn(4'b0001, mm, 4'b0001, {24'h0, 8'hF0});
    check("mask_chg_q", 32'(q), 32'(xacc ^ 8'h0F));
    req = '0;

    // All-zero captured mask
    do_txn(4'b0010, '0, 4'b0000, '0);

    // Randomized transactions with random post-grant disturbance and idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [NREQ-1:0] r;
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_txn(r, {$urandom()}, NREQ'($urandom()), {$urandom()});
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        tick();
        check_quiet("rand_gap");
      end
    end

    // Reset asserted during TOGGLE aborts the transaction
    mm = {4{8'h5A}};
    req      = 4'b0100;
    req_mask = mm;
    tick();
    check("abort_pre_t_out", 32'(t_out), 32'(8'h5A));
    #2;
    rst = 1'b0;
    #1;
    m_q = '0; m_rr = 0; m_grant = 0;
    req = '0;
    check_quiet("abort_now");
    check("abort_grant", 32'(grant_id), 32'(0));
    tick();
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("abort_after");
    end

    // First arbitration after reset starts from pointer 0
    do_txn(4'b1010, {$urandom()}, 4'b0000, '0);
    check("post_rst_grant", 32'(grant_id), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
